// File: rtl/dma_rd_engine.sv
// Host-memory DMA read engine: splits one read command into MRd TLPs bounded by max-read-request
// and 4 KB pages, tracks tags until completion. Define DMA_RD_TIMEOUT_EN for the drain timeout.
module dma_rd_engine #(
    parameter int unsigned DATA_WIDTH     = 256,
    parameter int unsigned NUM_TAGS       = 32,
    parameter int unsigned TAG_BASE       = 0,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic                  user_clk,
    input  logic                  user_reset_p,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [63:0]           cmd_addr,
    input  logic [15:0]           cmd_dw_len,
    input  logic [2:0]            cfg_max_read_req,
    output logic                  rq_valid,
    input  logic                  rq_ready,
    output logic [3:0]            rq_type,
    output logic [63:0]           rq_addr,
    output logic [10:0]           rq_payload_dw_count,
    output logic [7:0]            rq_tag,
    output logic [2:0]            rq_tc,
    output logic                  rq_payload_sop,
    output logic                  rq_payload_last,
    output logic [DATA_WIDTH-1:0] rq_payload,
    input  logic                  rc_valid,
    input  logic [7:0]            rc_tag,
    input  logic                  rc_request_completed,
    input  logic [3:0]            rc_err_code,
    output logic                  busy,
    output logic                  done,
    output logic                  err_cpl,
    output logic                  err_timeout,
    output logic [5:0]            outstanding
);

    typedef enum logic [2:0] {IDLE, CALC, ISSUE, DRAIN, DONE} state_t;
    state_t state, state_n;

    logic [63:0]         addr_q;
    logic [15:0]         remaining;
    logic [15:0]         rem_after;
    logic [7:0]          tag_idx;
    logic [NUM_TAGS-1:0] bitmap, bitmap_n;
    logic [2:0]          cfg_sat;
    logic [16:0]         maxdw, bnd, chunk;
    logic                have_free;
    logic [7:0]          free_idx;
    logic [7:0]          rc_rel;
    logic                free_hit;
    logic                accept, alloc, tmo_hit;
    logic [5:0]          pop;
    logic                unused_ok;

    assign rq_type         = 4'b0000;
    assign rq_tc           = '0;
    assign rq_payload_sop  = 1'b1;
    assign rq_payload_last = 1'b1;
    assign rq_payload      = '0;

    assign accept    = cmd_valid && cmd_ready;
    assign alloc     = rq_valid && rq_ready;
    assign rem_after = remaining - {5'd0, rq_payload_dw_count};
    assign rc_rel    = rc_tag - 8'(TAG_BASE);

    // Chunk = min(remaining, max read request, distance to the next 4 KB page).
    always_comb begin
        cfg_sat = (cfg_max_read_req > 3'd5) ? 3'd5 : cfg_max_read_req;
        maxdw   = 17'd32 << cfg_sat;
        bnd     = 17'd1024 - {7'd0, addr_q[11:2]};
        chunk   = {1'b0, remaining};
        if (maxdw < chunk) chunk = maxdw;
        if (bnd < chunk) chunk = bnd;
    end

    always_comb begin
        have_free = 1'b0;
        free_idx  = '0;
        for (int unsigned i = NUM_TAGS; i > 0; i--) begin
            if (!bitmap[i-1]) begin
                have_free = 1'b1;
                free_idx  = 8'(i - 1);
            end
        end
    end

    // Free only tags that are in range and actually busy; stale or foreign tags fall through.
    always_comb begin
        bitmap_n = bitmap;
        free_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_TAGS; i++) begin
            if (alloc && tag_idx == 8'(i)) bitmap_n[i] = 1'b1;
            if (rc_valid && rc_request_completed && rc_rel == 8'(i) && bitmap[i]) begin
                bitmap_n[i] = 1'b0;
                free_hit    = 1'b1;
            end
        end
        if (tmo_hit) bitmap_n = '0;
        pop = '0;
        for (int unsigned i = 0; i < NUM_TAGS; i++) pop = pop + 6'(bitmap_n[i]);
    end

    always_ff @(posedge user_clk) begin
        if (user_reset_p) state <= IDLE;
        else              state <= state_n;
    end

    always_comb begin
        state_n   = state;
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        rq_valid  = (state == ISSUE);
        case (state)
            IDLE:  if (accept) state_n = (cmd_dw_len == 16'd0) ? DONE : CALC;
            CALC:  if (have_free) state_n = ISSUE;
            ISSUE: if (rq_ready) state_n = (rem_after == 16'd0) ? DRAIN : CALC;
            DRAIN: if (bitmap == '0 || tmo_hit) state_n = DONE;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (user_reset_p) begin
            addr_q              <= '0;
            remaining           <= '0;
            tag_idx             <= '0;
            bitmap              <= '0;
            outstanding         <= '0;
            rq_addr             <= '0;
            rq_payload_dw_count <= '0;
            rq_tag              <= '0;
            done                <= 1'b0;
            err_cpl             <= 1'b0;
        end else begin
            done        <= (state == DONE);
            bitmap      <= bitmap_n;
            outstanding <= pop;
            if (accept) begin
                addr_q    <= {cmd_addr[63:2], 2'b00};
                remaining <= cmd_dw_len;
                err_cpl   <= 1'b0;
            end
            if (state == CALC && have_free) begin
                rq_addr             <= addr_q;
                rq_payload_dw_count <= chunk[10:0];
                tag_idx             <= free_idx;
                rq_tag              <= 8'(TAG_BASE) + free_idx;
            end
            if (alloc) begin
                addr_q    <= addr_q + {51'd0, rq_payload_dw_count, 2'b00};
                remaining <= rem_after;
            end
            if (rc_valid && rc_err_code != 4'd0) err_cpl <= 1'b1;
        end
    end

`ifdef DMA_RD_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    assign tmo_hit   = (state == DRAIN) && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign unused_ok = ^cmd_addr[1:0];

    always_ff @(posedge user_clk) begin
        if (user_reset_p) begin
            tmo_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (accept)  err_timeout <= 1'b0;
            if (tmo_hit) err_timeout <= 1'b1;
            if ((state != DRAIN && state_n == DRAIN) || free_hit) tmo_cnt <= '0;
            else if (tmo_cnt != '1)                               tmo_cnt <= tmo_cnt + 32'd1;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign err_timeout = 1'b0;
    assign unused_ok   = ^{cmd_addr[1:0], free_hit, 1'(TIMEOUT_CYCLES % 2)};
`endif

endmodule

// File: doc/dma_rd_engine.md
Name: dma_rd_engine

Overview:
- Host-memory DMA read engine inside user_logic; drives the RQ formatter inputs and consumes RC parser completion status.
- Accepts one read command (host address, DW length) at a time.
- Splits the command into Memory Read TLPs bounded by cfg_max_read_req and 4 KB boundaries, allocates tags from a local pool, and tracks outstanding completions.
- Pulses done once every issued tag has completed.

Parameters:
- DATA_WIDTH, 256, width of rq_payload.
- NUM_TAGS, 32, tag pool size, 1..32.
- TAG_BASE, 0, first tag value; rq_tag = TAG_BASE + index.
- TIMEOUT_CYCLES, 65536, drain timeout; used only with the optional feature.

Ports:
- user_clk  in  1  clock.
- user_reset_p  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_addr  in  64  host byte address; bits [1:0] ignored (treated as 0).
- cmd_dw_len  in  16  transfer length in DW.
- cfg_max_read_req  in  3  0=128B … 5=4096B; values above 5 treated as 5.
- rq_valid  out  1  request valid.
- rq_ready  in  1  formatter ready.
- rq_type  out  4  constant 4'b0000 (MRd).
- rq_addr  out  64  request address.
- rq_payload_dw_count  out  11  request DW count, 1..1024.
- rq_tag  out  8  allocated tag.
- rq_tc  out  3  constant 0.
- rq_payload_sop  out  1  constant 1.
- rq_payload_last  out  1  constant 1.
- rq_payload  out  DATA_WIDTH  constant 0.
- rc_valid  in  1  completion beat valid.
- rc_tag  in  8  completion tag.
- rc_request_completed  in  1  final completion for this tag.
- rc_err_code  in  4  nonzero means error.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse.
- err_cpl  out  1  sticky completion error; cleared on next command accept.
- err_timeout  out  1  sticky drain timeout; cleared on next command accept.
- outstanding  out  6  count of busy tags.

Behaviour:
- Reset values: rq_valid=0, rq_addr=0, rq_payload_dw_count=0, rq_tag=0, done=0, err_cpl=0, err_timeout=0, outstanding=0, busy=0, cmd_ready=1 (IDLE); tag bitmap cleared. Constant outputs are unaffected by reset.
- Reset mid-operation abandons all state. Completions arriving after reset are ignored, because their tags are not busy.
- States: IDLE, CALC, ISSUE, DRAIN, DONE.
- IDLE:
  - On cmd_valid&&cmd_ready: latch addr (low 2 bits forced to 0) and remaining=cmd_dw_len; clear err flags.
  - Go to DONE if cmd_dw_len==0, else to CALC.
- CALC:
  - maxdw = 32<<min(cfg,5).
  - bnd = 1024 - addr[11:2].
  - chunk = min(remaining, maxdw, bnd), computed in 17-bit arithmetic.
  - If the bitmap has a free tag: select the lowest free index, register rq fields, go to ISSUE. Otherwise stay in CALC, recomputing each cycle.
- ISSUE:
  - rq_valid=1; all rq fields held stable until rq_ready.
  - On handshake (same cycle): mark tag busy, addr += chunk*4, remaining -= chunk, rq_valid drops the next cycle.
  - Then go to DRAIN if remaining==0, else CALC.
- Latency: command accept at cycle N → rq_valid at N+2. Minimum request spacing is 2 cycles (CALC+ISSUE).
- Tag free: rc_valid && rc_request_completed && (rc_tag-TAG_BASE)<NUM_TAGS && bit set → clear the bit.
  - Beats with rc_request_completed=0 never free a tag.
  - Unknown or idle tags are ignored.
- rc_valid && rc_err_code!=0 sets err_cpl. The tag is still freed only per the rule above.
- Simultaneous allocate and free in one cycle: both apply; outstanding = popcount of the bitmap, registered.
- DRAIN: wait for outstanding==0 (bitmap empty), then go to DONE.
- DONE: done=1 for one cycle, then IDLE. cmd_ready stays 0 during DONE.
- Completions keep freeing tags in every state.

Optional Feature:
- Macro: DMA_RD_TIMEOUT_EN.
- With the macro:
  - A cycle counter resets on entering DRAIN and on every tag free.
  - When it reaches TIMEOUT_CYCLES-1 in DRAIN: set err_timeout, clear the whole bitmap, go to DONE.
- Without the macro: no counter; err_timeout is tied 0; DRAIN waits indefinitely.

Test Plan:
- Boundary split: addr=0x0000_0000_1000_0F80, len=256, cfg=1, rq_ready=1, completions returned promptly → 5 MRd:
  - 32 DW @..0F80, tag 0
  - 64 DW @..1000, tag 1
  - 64 DW @..1100
  - 64 DW @..1200
  - 32 DW @..1300
  - then done pulse.
- Max size: addr=0x2000, len=2048, cfg=5 → two 1024-DW requests @0x2000 and @0x3000; first rq_valid 2 cycles after accept.
- Tag exhaustion: NUM_TAGS=4, len=1024, cfg=0, no completions → exactly 4 requests (tags 0..3), then rq_valid stays 0; completing tag 2 → next request uses tag 2.
- Backpressure and error:
  - Hold rq_ready=0 for 10 cycles → rq_addr, rq_tag and rq_payload_dw_count are stable.
  - A completion with rc_err_code=4'h1 and request_completed=1 → err_cpl=1, tag freed, done still pulses.
- Zero length and reset: len=0 → no rq_valid, done 2 cycles after accept; assert reset in ISSUE → rq_valid=0, busy=0, outstanding=0 the next cycle.
- With DMA_RD_TIMEOUT_EN, TIMEOUT_CYCLES=100, one completion withheld → err_timeout=1 and done 100 cycles after the last free.
